udp_tx: RTL
===========

Name: udp_tx

Overview:
UDP transmit layer; the transmit-side counterpart of the UDP receiver in the Ethernet stack. The application writes a payload into an internal 2048x8 buffer, then pulses start. The block computes the UDP checksum over the pseudo-header, header and payload. It then requests the IP layer and streams the 8-byte UDP header followed by the payload, one byte per clk.

Parameters:
MAX_PAYLOAD, 1472, largest accepted payload length in bytes
PROTOCOL, 8'h11, protocol byte used in the pseudo-header

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
app_wr_en  in  1  payload buffer write enable (ignored while udp_tx_busy)
app_wr_addr  in  11  payload buffer write address (byte index)
app_wr_data  in  8  payload buffer write data
app_tx_start  in  1  one-cycle pulse: begin transmit (ignored while busy)
app_tx_length  in  16  payload byte count, sampled on start
src_ip_addr  in  32  source IP, sampled on start
dst_ip_addr  in  32  destination IP, sampled on start
src_port  in  16  UDP source port, sampled on start
dst_port  in  16  UDP destination port, sampled on start
udp_tx_req  out  1  request to IP layer; held high until ack
udp_tx_ack  in  1  IP layer grants; byte stream starts next cycle
udp_tx_length  out  16  UDP length (payload+8); stable while busy
udp_tx_data  out  8  outgoing byte
udp_tx_valid  out  1  udp_tx_data valid
udp_tx_busy  out  1  high from accepted start until done
udp_tx_done  out  1  one-cycle pulse after the last byte
udp_tx_error  out  1  one-cycle pulse: start rejected (length > MAX_PAYLOAD)

Behaviour:
- Reset: state IDLE. udp_tx_req, udp_tx_valid, udp_tx_busy, udp_tx_done and udp_tx_error are 0. udp_tx_data and udp_tx_length are 0. Buffer contents are not cleared. Reset mid-frame aborts immediately; no done pulse follows.
- Buffer: simple dual-port RAM with 1-cycle registered read. The write port belongs to the application. The read port is used internally.
- States: IDLE -> CALC -> FOLD -> REQ -> SEND_HEAD -> SEND_DATA -> END -> IDLE.
- IDLE: on start with length <= MAX_PAYLOAD, latch all inputs, set udp_tx_length = length+8, assert busy, go to CALC. On start with length > MAX_PAYLOAD, pulse udp_tx_error and stay in IDLE.
- CALC: 32-bit accumulator, initialised to the sum of:
  - src_ip[31:16], src_ip[15:0], dst_ip[31:16], dst_ip[15:0]
  - {8'h00, PROTOCOL} and udp_length
  - src_port, dst_port and udp_length (checksum field = 0)
- CALC payload pass: read the buffer sequentially from address 0 and add big-endian 16-bit words {byte[2k], byte[2k+1]}. For odd length, the last word is {byte[n-1], 8'h00}. Length 0 skips the read pass.
- FOLD: two folds, sum = sum[15:0] + sum[31:16], then invert. A result of 16'h0000 is transmitted as 16'hFFFF.
- REQ: udp_tx_req = 1. When udp_tx_ack is sampled high in cycle N, drop req in N+1 and output header byte 0 in N+1.
- SEND_HEAD: 8 contiguous valid bytes, MSB first: src_port, dst_port, udp_length, checksum.
- SEND_DATA: payload bytes 0..n-1, contiguous, valid held high. Reads are prefetched so there is no gap between the last header byte and payload byte 0.
- END: udp_tx_done pulses in the cycle after the last valid byte, and busy drops in the same cycle. Total valid cycles = length+8. With length 0, only the header is sent.
- udp_tx_ack outside REQ is ignored.
- app_tx_start coincident with done is ignored. A new start is accepted from the following cycle.
- Arithmetic: all additions are unsigned. The address counter is 11 bits; wrap-around is impossible because of the MAX_PAYLOAD limit.

Test Plan:
1. src 0xC0A8010A, dst 0xC0A80164, ports 0x1F90/0x1F90, payload "ABCD" (41 42 43 44), len 4, ack after 3 cycles -> udp_tx_length 0x000C. 12 contiguous bytes: 1F 90 1F 90 00 0C B8 70 41 42 43 44. Done pulse 1 cycle after byte 0x44.
2. Same addresses and ports, payload "ABC", len 3 -> bytes 1F 90 1F 90 00 0B B8 B6 41 42 43; udp_tx_length 0x000B.
3. len 0 -> 8 header bytes only; udp_length 0x0008; checksum equals the inverted pseudo-header+header sum; done follows.
4. len 1473 -> udp_tx_error pulses 1 cycle; busy and req stay 0; no bytes are output.
5. Second start and app_wr_en pulses issued during transmission of test 1 -> both ignored; output bytes are identical to test 1. A start in the cycle after done is accepted.
6. rstn low for 1 cycle during SEND_DATA -> next cycle valid/req/busy = 0, no done pulse. A subsequent start transmits a correct frame.

Source files
------------

// File: rtl/udp_tx.sv
// UDP transmit layer: buffers an application payload, computes the UDP checksum
// over pseudo-header, header and payload, then streams header and payload bytewise.
module udp_tx #(
   parameter int         MAX_PAYLOAD = 1472,
   parameter logic [7:0] PROTOCOL    = 8'h11
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        app_wr_en,
   input  logic [10:0] app_wr_addr,
   input  logic [7:0]  app_wr_data,
   input  logic        app_tx_start,
   input  logic [15:0] app_tx_length,
   input  logic [31:0] src_ip_addr,
   input  logic [31:0] dst_ip_addr,
   input  logic [15:0] src_port,
   input  logic [15:0] dst_port,
   output logic        udp_tx_req,
   input  logic        udp_tx_ack,
   output logic [15:0] udp_tx_length,
   output logic [7:0]  udp_tx_data,
   output logic        udp_tx_valid,
   output logic        udp_tx_busy,
   output logic        udp_tx_done,
   output logic        udp_tx_error
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CALC      = 3'd1,
      S_FOLD      = 3'd2,
      S_REQ       = 3'd3,
      S_SEND_HEAD = 3'd4,
      S_SEND_DATA = 3'd5,
      S_END       = 3'd6
   } state_t;

   localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

   // Pseudo-header plus UDP header contribution (checksum field counted as zero).
   function automatic logic [31:0] pseudo_sum(input logic [31:0] sip, input logic [31:0] dip,
                                              input logic [15:0] sp, input logic [15:0] dp,
                                              input logic [15:0] ulen);
      return {16'd0, sip[31:16]} + {16'd0, sip[15:0]} + {16'd0, dip[31:16]} + {16'd0, dip[15:0]}
           + {24'd0, PROTOCOL} + {16'd0, ulen} + {16'd0, sp} + {16'd0, dp} + {16'd0, ulen};
   endfunction

   // One's-complement fold twice, invert; zero is sent as all-ones.
   function automatic logic [15:0] fold_csum(input logic [31:0] acc);
      logic [16:0] f1;
      logic [16:0] f2;
      logic [15:0] res;
      f1  = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
      f2  = {1'b0, f1[15:0]} + {16'd0, f1[16]};
      res = ~f2[15:0];
      if (res == 16'h0000) begin
         res = 16'hFFFF;
      end else begin
         res = res;
      end
      return res;
   endfunction

   function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [15:0] sp,
                                           input logic [15:0] dp, input logic [15:0] ulen,
                                           input logic [15:0] ck);
      logic [7:0] b;
      case (idx)
         3'd0:    b = sp[15:8];
         3'd1:    b = sp[7:0];
         3'd2:    b = dp[15:8];
         3'd3:    b = dp[7:0];
         3'd4:    b = ulen[15:8];
         3'd5:    b = ulen[7:0];
         3'd6:    b = ck[15:8];
         3'd7:    b = ck[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   state_t      state_r, state_nx;
   logic        req_r, req_nx;
   logic        valid_r, valid_nx;
   logic [7:0]  data_r, data_nx;
   logic        busy_r, busy_nx;
   logic        done_r, done_nx;
   logic        err_r, err_nx;
   logic [15:0] ulen_r, ulen_nx;
   logic [15:0] len_r, len_nx;
   logic [15:0] sport_r, sport_nx;
   logic [15:0] dport_r, dport_nx;
   logic [31:0] acc_r, acc_nx;
   logic [15:0] csum_r, csum_nx;
   logic [10:0] rd_addr_r, rd_addr_nx;
   logic [3:0]  hcnt_r, hcnt_nx;
   logic [7:0]  rd_data_r;
   logic [7:0]  mem_r [0:2047];
   logic        in_range_s;

   // Payload RAM: application write port, internal read port addressed by next read address
   // so that rd_data_r always holds mem[rd_addr_r].
   always_ff @(posedge clk) begin
      if (app_wr_en && !busy_r) begin
         mem_r[app_wr_addr] <= app_wr_data;
      end
      rd_data_r <= mem_r[rd_addr_nx];
   end

   assign in_range_s = ({5'd0, rd_addr_r} < len_r);

   // Next-state and next-output logic.
   always_comb begin
      state_nx   = state_r;
      req_nx     = req_r;
      valid_nx   = valid_r;
      data_nx    = data_r;
      busy_nx    = busy_r;
      done_nx    = 1'b0;
      err_nx     = 1'b0;
      ulen_nx    = ulen_r;
      len_nx     = len_r;
      sport_nx   = sport_r;
      dport_nx   = dport_r;
      acc_nx     = acc_r;
      csum_nx    = csum_r;
      rd_addr_nx = rd_addr_r;
      hcnt_nx    = hcnt_r;
      case (state_r)
         S_IDLE: begin
            if (app_tx_start) begin
               if (app_tx_length > MAX_LEN) begin
                  err_nx = 1'b1;
               end else begin
                  len_nx     = app_tx_length;
                  ulen_nx    = app_tx_length + 16'd8;
                  sport_nx   = src_port;
                  dport_nx   = dst_port;
                  acc_nx     = pseudo_sum(src_ip_addr, dst_ip_addr, src_port, dst_port,
                                          app_tx_length + 16'd8);
                  rd_addr_nx = 11'd0;
                  busy_nx    = 1'b1;
                  state_nx   = S_CALC;
               end
            end else begin
               rd_addr_nx = 11'd0;
            end
         end
         S_CALC: begin
            // Even byte index is the high half of a big-endian word.
            if (in_range_s) begin
               acc_nx     = acc_r + (rd_addr_r[0] ? {24'd0, rd_data_r} : {16'd0, rd_data_r, 8'h00});
               rd_addr_nx = rd_addr_r + 11'd1;
            end else begin
               state_nx = S_FOLD;
            end
         end
         S_FOLD: begin
            csum_nx    = fold_csum(acc_r);
            rd_addr_nx = 11'd0;
            req_nx     = 1'b1;
            state_nx   = S_REQ;
         end
         S_REQ: begin
            if (udp_tx_ack) begin
               req_nx   = 1'b0;
               valid_nx = 1'b1;
               data_nx  = hdr_byte(3'd0, sport_r, dport_r, ulen_r, csum_r);
               hcnt_nx  = 4'd1;
               state_nx = S_SEND_HEAD;
            end else begin
               req_nx = 1'b1;
            end
         end
         S_SEND_HEAD: begin
            if (hcnt_r < 4'd8) begin
               data_nx = hdr_byte(hcnt_r[2:0], sport_r, dport_r, ulen_r, csum_r);
               hcnt_nx = hcnt_r + 4'd1;
            end else if (len_r == 16'd0) begin
               valid_nx = 1'b0;
               data_nx  = 8'h00;
               done_nx  = 1'b1;
               busy_nx  = 1'b0;
               state_nx = S_END;
            end else begin
               // Byte 0 was prefetched while the header was going out.
               data_nx    = rd_data_r;
               rd_addr_nx = rd_addr_r + 11'd1;
               state_nx   = S_SEND_DATA;
            end
         end
         S_SEND_DATA: begin
            if (in_range_s) begin
               data_nx    = rd_data_r;
               rd_addr_nx = rd_addr_r + 11'd1;
            end else begin
               valid_nx = 1'b0;
               data_nx  = 8'h00;
               done_nx  = 1'b1;
               busy_nx  = 1'b0;
               state_nx = S_END;
            end
         end
         S_END: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
            req_nx   = 1'b0;
            valid_nx = 1'b0;
            busy_nx  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r   <= S_IDLE;
         req_r     <= 1'b0;
         valid_r   <= 1'b0;
         data_r    <= 8'h00;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
         ulen_r    <= 16'd0;
         len_r     <= 16'd0;
         sport_r   <= 16'd0;
         dport_r   <= 16'd0;
         acc_r     <= 32'd0;
         csum_r    <= 16'd0;
         rd_addr_r <= 11'd0;
         hcnt_r    <= 4'd0;
      end else begin
         state_r   <= state_nx;
         req_r     <= req_nx;
         valid_r   <= valid_nx;
         data_r    <= data_nx;
         busy_r    <= busy_nx;
         done_r    <= done_nx;
         err_r     <= err_nx;
         ulen_r    <= ulen_nx;
         len_r     <= len_nx;
         sport_r   <= sport_nx;
         dport_r   <= dport_nx;
         acc_r     <= acc_nx;
         csum_r    <= csum_nx;
         rd_addr_r <= rd_addr_nx;
         hcnt_r    <= hcnt_nx;
      end
   end

   assign udp_tx_req    = req_r;
   assign udp_tx_valid  = valid_r;
   assign udp_tx_data   = data_r;
   assign udp_tx_busy   = busy_r;
   assign udp_tx_done   = done_r;
   assign udp_tx_error  = err_r;
   assign udp_tx_length = ulen_r;

endmodule
